// File: rtl/regfile_pkg.sv
// Shared types and default parameters for the multi-port decode-stage register file.
package regfile_pkg;

  localparam int RF_DATA_WIDTH      = 32;
  localparam int RF_ADDRESS_WIDTH   = 5;
  localparam int RF_NUM_READ        = 2;
  localparam int RF_NUM_WRITE       = 1;
  localparam int RF_ZERO_REG        = 1;
  localparam int RF_BYPASS          = 1;
  localparam int RF_CLEAR_PER_CYCLE = 4;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sequencer: walks the storage array in fixed-size chunks, then raises ready.
//
// state    | meaning
// RF_CLEAR | zeroing chunk at clr_idx each cycle; ready=0
// RF_RUN   | clear done; normal reads/writes; ready=1
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = RF_ADDRESS_WIDTH,
  parameter int CLEAR_PER_CYCLE = RF_CLEAR_PER_CYCLE
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     clr_en,
  output logic [ADDRESS_WIDTH-1:0] clr_base,
  output logic                     ready
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_BASE = ADDRESS_WIDTH'(DEPTH - CLEAR_PER_CYCLE);
  localparam logic [ADDRESS_WIDTH-1:0] STEP      = ADDRESS_WIDTH'(CLEAR_PER_CYCLE);

  rf_state_t                  state;
  rf_state_t                  state_next;
  logic [ADDRESS_WIDTH-1:0]   clr_idx;
  logic [ADDRESS_WIDTH-1:0]   clr_idx_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RF_CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
    end
  end

  // The last chunk holds clr_idx instead of advancing, so it never wraps inside CLEAR.
  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    case (state)
      RF_CLEAR: begin
        if (clr_idx == LAST_BASE) begin
          state_next = RF_RUN;
        end else begin
          clr_idx_next = clr_idx + STEP;
        end
      end
      RF_RUN: begin
        state_next = RF_RUN;
      end
      default: begin
        state_next   = RF_CLEAR;
        clr_idx_next = '0;
      end
    endcase
  end

  always_comb begin
    clr_en   = 1'b0;
    ready    = 1'b0;
    clr_base = clr_idx;
    case (state)
      RF_CLEAR: clr_en = 1'b1;
      RF_RUN:   ready  = 1'b1;
      default:  clr_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with hardwired-zero entry, optional write-to-read bypass
// and a chunked post-reset clear that gates both reads and writes until done.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH      = RF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH   = RF_ADDRESS_WIDTH,
  parameter int NUM_READ        = RF_NUM_READ,
  parameter int NUM_WRITE       = RF_NUM_WRITE,
  parameter int ZERO_REG        = RF_ZERO_REG,
  parameter int BYPASS          = RF_BYPASS,
  parameter int CLEAR_PER_CYCLE = RF_CLEAR_PER_CYCLE
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0]  ra,
  output logic [NUM_READ*DATA_WIDTH-1:0]     rd,
  input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wa,
  input  logic [NUM_WRITE-1:0]               we,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]    wd,
  output logic                               ready
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  if ((DEPTH % CLEAR_PER_CYCLE) != 0) begin : g_bad_clear
    $error("CLEAR_PER_CYCLE must divide DEPTH");
  end
  if ((NUM_WRITE < 1) || (NUM_WRITE > 2)) begin : g_bad_nwrite
    $error("NUM_WRITE must be 1 or 2");
  end

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic                     clr_en;
  logic [ADDRESS_WIDTH-1:0] clr_base;

  logic [ADDRESS_WIDTH-1:0] wa_p [NUM_WRITE];
  logic [DATA_WIDTH-1:0]    wd_p [NUM_WRITE];

  for (genvar j = 0; j < NUM_WRITE; j++) begin : g_wsplit
    assign wa_p[j] = wa[j*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign wd_p[j] = wd[j*DATA_WIDTH +: DATA_WIDTH];
  end

  regfile_clear_fsm #(
    .ADDRESS_WIDTH   (ADDRESS_WIDTH),
    .CLEAR_PER_CYCLE (CLEAR_PER_CYCLE)
  ) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_en   (clr_en),
    .clr_base (clr_base),
    .ready    (ready)
  );

  // Later write ports are assigned last, so the higher index wins on an address clash.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      for (int k = 0; k < CLEAR_PER_CYCLE; k++) begin
        mem[clr_base + ADDRESS_WIDTH'(k)] <= '0;
      end
    end else if (ready) begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (we[j] && !((ZERO_REG != 0) && (wa_p[j] == '0))) begin
          mem[wa_p[j]] <= wd_p[j];
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    logic [ADDRESS_WIDTH-1:0] ra_i;
    logic [DATA_WIDTH-1:0]    rd_i;

    assign ra_i = ra[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];

    // Checks are applied lowest priority first so later overrides win.
    always_comb begin
      rd_i = mem[ra_i];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (we[j] && (wa_p[j] == ra_i)) begin
            rd_i = wd_p[j];
          end
        end
      end
      if ((ZERO_REG != 0) && (ra_i == '0)) begin
        rd_i = '0;
      end
      if (!ready) begin
        rd_i = '0;
      end
    end

    assign rd[i*DATA_WIDTH +: DATA_WIDTH] = rd_i;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: a bypassing and a non-bypassing instance share stimulus.
module tb_register_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int NW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR*AW-1:0] ra = '0;
  logic [NW*AW-1:0] wa = '0;
  logic [NW-1:0]    we = '0;
  logic [NW*DW-1:0] wd = '0;
  logic [NR*DW-1:0] rd_a;
  logic [NR*DW-1:0] rd_b;
  logic             ready_a;
  logic             ready_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  register_file_mp #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW),
    .ZERO_REG(1), .BYPASS(1), .CLEAR_PER_CYCLE(4)
  ) dut_a (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd_a), .wa(wa), .we(we), .wd(wd), .ready(ready_a)
  );

  register_file_mp #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW),
    .ZERO_REG(1), .BYPASS(0), .CLEAR_PER_CYCLE(4)
  ) dut_b (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd_b), .wa(wa), .we(we), .wd(wd), .ready(ready_b)
  );

  function automatic logic [DW-1:0] rda(input int i);
    return rd_a[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] rdb(input int i);
    return rd_b[i*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    ra = {a2, a1, a0};
    #1;
  endtask

  task automatic set_wr(input logic [1:0] en,
                        input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    we = en;
    wa = {a1, a0};
    wd = {d1, d0};
    #1;
  endtask

  task automatic test_reset();
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    set_ra(5'd3, 5'd17, 5'd31);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      total++;
      if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
        bad++;
        $display("FAIL reset_ready_low cycle=%0d got a=%b b=%b want 0", c, ready_a, ready_b);
      end
      total++;
      if (rd_a !== '0 || rd_b !== '0) begin
        bad++;
        $display("FAIL reset_rd_zero cycle=%0d got a=%h b=%h want 0", c, rd_a, rd_b);
      end
      tick();
    end
    total++;
    if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_high got a=%b b=%b want 1", ready_a, ready_b);
    end
    for (int e = 0; e < 32; e++) begin
      set_ra(5'(e), 5'(e), 5'(e));
      total++;
      if (rda(0) !== 32'h0 || rdb(2) !== 32'h0) begin
        bad++;
        $display("FAIL reset_entry_zero x%0d got a=%h b=%h want 0", e, rda(0), rdb(2));
      end
    end
  endtask

  task automatic test_bypass();
    set_ra(5'd5, 5'd0, 5'd0);
    set_wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
    total++;
    if (rda(0) !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL bypass_same_cycle got %h want deadbeef", rda(0));
    end
    total++;
    if (rdb(0) !== 32'h0) begin
      bad++;
      $display("FAIL nobypass_same_cycle got %h want 0", rdb(0));
    end
    tick();
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    total++;
    if (rda(0) !== 32'hDEADBEEF || rdb(0) !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL write_next_cycle got a=%h b=%h want deadbeef", rda(0), rdb(0));
    end
  endtask

  task automatic test_zero_reg();
    set_ra(5'd0, 5'd0, 5'd0);
    set_wr(2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0);
    total++;
    if (rda(0) !== 32'h0 || rdb(0) !== 32'h0) begin
      bad++;
      $display("FAIL zero_same_cycle got a=%h b=%h want 0", rda(0), rdb(0));
    end
    tick();
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    total++;
    if (rda(0) !== 32'h0 || rdb(0) !== 32'h0) begin
      bad++;
      $display("FAIL zero_next_cycle got a=%h b=%h want 0", rda(0), rdb(0));
    end
  endtask

  task automatic test_dual_write();
    set_ra(5'd7, 5'd0, 5'd0);
    set_wr(2'b11, 5'd7, 32'h1111, 5'd7, 32'h2222);
    total++;
    if (rda(0) !== 32'h2222) begin
      bad++;
      $display("FAIL dual_bypass_prio got %h want 2222", rda(0));
    end
    tick();
    set_wr(2'b11, 5'd8, 32'h88, 5'd9, 32'h99);
    tick();
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    set_ra(5'd7, 5'd8, 5'd9);
    total++;
    if (rda(0) !== 32'h2222 || rdb(0) !== 32'h2222) begin
      bad++;
      $display("FAIL dual_same_addr got a=%h b=%h want 2222", rda(0), rdb(0));
    end
    total++;
    if (rdb(1) !== 32'h88 || rdb(2) !== 32'h99) begin
      bad++;
      $display("FAIL dual_diff_addr got x8=%h x9=%h want 88 99", rdb(1), rdb(2));
    end
  endtask

  task automatic test_back_to_back();
    set_wr(2'b01, 5'd3, 32'h1, 5'd0, 32'h0);
    tick();
    set_wr(2'b01, 5'd4, 32'h2, 5'd0, 32'h0);
    tick();
    set_wr(2'b01, 5'd3, 32'h3, 5'd0, 32'h0);
    tick();
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    set_ra(5'd3, 5'd4, 5'd5);
    total++;
    if (rdb(0) !== 32'h3 || rdb(1) !== 32'h2 || rdb(2) !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL back_to_back got %h %h %h want 3 2 deadbeef", rdb(0), rdb(1), rdb(2));
    end
  endtask

  task automatic test_multi_read();
    set_wr(2'b01, 5'd1, 32'h0BADF00D, 5'd0, 32'h0);
    tick();
    set_ra(5'd1, 5'd2, 5'd1);
    set_wr(2'b01, 5'd2, 32'hA5A5A5A5, 5'd0, 32'h0);
    total++;
    if (rd_a !== {32'h0BADF00D, 32'hA5A5A5A5, 32'h0BADF00D}) begin
      bad++;
      $display("FAIL multi_read_bypass got %h want 0badf00d_a5a5a5a5_0badf00d", rd_a);
    end
    total++;
    if (rd_b !== {32'h0BADF00D, 32'h0, 32'h0BADF00D}) begin
      bad++;
      $display("FAIL multi_read_nobypass got %h want 0badf00d_00000000_0badf00d", rd_b);
    end
    tick();
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    total++;
    if (rdb(1) !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL multi_read_after got %h want a5a5a5a5", rdb(1));
    end
  endtask

  task automatic test_reset_mid_clear();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) set_wr(2'b01, 5'd10, 32'hFFFF, 5'd0, 32'h0);
      else        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      total++;
      if (ready_a !== 1'b0) begin
        bad++;
        $display("FAIL restart_ready_low cycle=%0d got %b want 0", c, ready_a);
      end
      tick();
    end
    set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    total++;
    if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
      bad++;
      $display("FAIL restart_ready_high got a=%b b=%b want 1", ready_a, ready_b);
    end
    set_ra(5'd10, 5'd5, 5'd7);
    total++;
    if (rdb(0) !== 32'h0) begin
      bad++;
      $display("FAIL clear_write_dropped got %h want 0", rdb(0));
    end
    total++;
    if (rdb(1) !== 32'h0 || rdb(2) !== 32'h0 || rda(1) !== 32'h0) begin
      bad++;
      $display("FAIL restart_cleared got x5=%h x7=%h want 0", rdb(1), rdb(2));
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_dual_write();
    test_back_to_back();
    test_multi_read();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
